fetch_redirect_unit: RTL and testbench
======================================

# fetch_redirect_unit

Owns the program counter and the instruction-memory fetch handshake for the multicycle RV32I core. It sits directly downstream of `control_transfer`: it consumes `br_en` together with the execute-stage branch/jump target and redirects fetch. Redirects discard any fetch already in flight. Decode is fed through a one-entry valid/stall hold buffer.

## Interface
- `RESET_PC`, default 32'h6000_0000, first fetch address after reset
- `clk`  input  1  sole clock, rising edge
- `rst`  input  1  asynchronous, active-high reset
- `br_valid`  input  1  execute holds a valid branch or jump this cycle
- `br_en`  input  1  branch-taken decision from `control_transfer`
- `jump`  input  1  unconditional transfer (JAL/JALR); overrides `br_en`
- `target`  input  32  redirect address; bits [1:0] forced to 2'b00 internally
- `stall`  input  1  decode cannot accept the held instruction
- `imem_read`  output  1  fetch request, held until `imem_resp`
- `imem_addr`  output  32  fetch address, stable while `imem_read`=1
- `imem_resp`  input  1  one-cycle response strobe
- `imem_rdata`  input  32  instruction, valid with `imem_resp`
- `if_valid`  output  1  `if_pc`/`if_instr` hold a live instruction
- `if_pc`  output  32  PC of the held instruction
- `if_instr`  output  32  held instruction word
- `flush`  output  1  combinational; high in any cycle a redirect is accepted

## Operation
- `redirect` = `br_valid & (br_en | jump)`. `flush` = `redirect`.
- States: FETCH, VALID, DISCARD.
- FETCH: `imem_read`=1, `imem_addr`=`pc`.
  - `imem_resp` & !`redirect`: capture `imem_rdata` and `pc` into the hold buffer; go to VALID.
  - `redirect` & `imem_resp`: drop the response; `pc`<=`target`; stay in FETCH.
  - `redirect` & !`imem_resp`: `pc_pend`<=`target`; go to DISCARD.
- VALID: `if_valid`=1, `imem_read`=0.
  - `redirect`: drop the buffer; `pc`<=`target`; go to FETCH. Redirect has priority over `stall`.
  - !`stall`: the instruction is consumed; `pc`<=`pc`+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0); go to FETCH.
  - `stall`: hold buffer and outputs unchanged.
- DISCARD: `imem_read`=1 at the old `pc`; address unchanged per the memory protocol.
  - Further `redirect`: overwrites `pc_pend`; last one wins.
  - `imem_resp`: drop the data; `pc`<=`pc_pend` (or `target` if `redirect` in the same cycle); go to FETCH.
- `if_valid`=0 in FETCH and DISCARD.

## Timing
- Reset values, asserted asynchronously and held while `rst`=1:
  - state=FETCH, `pc`=`RESET_PC`, `pc_pend`=0.
  - `if_valid`=0, `if_pc`=`RESET_PC`, `if_instr`=0.
  - `imem_read` gated to 0 while `rst`=1, so it rises combinationally on deassertion.
- Reset mid-operation aborts every state. Instruction memory shares `rst`, so no stale response arrives afterwards.
- Latency:
  - `imem_resp` in cycle N gives `if_valid`=1 in cycle N+1.
  - Consumption in cycle M gives `imem_read`=1 for the next PC in cycle M+1.
  - A redirect accepted in cycle R gives `imem_addr`=`target` in cycle R+1, unless the unit enters DISCARD.
- Adjacent hold-buffer outputs are registered. `flush` is the only combinational output.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - Adds outputs `redirect_cnt[31:0]` and `discard_cnt[31:0]`, both reset to 0 and wrapping at 2^32.
  - `redirect_cnt` increments once per accepted redirect.
  - `discard_cnt` increments once per dropped memory response or dropped hold-buffer instruction.
- Undefined: neither port exists and no counter logic is present. Functional behaviour is identical either way.

## Structure
- `definitions.sv` keeps the `FUNCT3_*` macros.
- `fetch_state_t` (FETCH/VALID/DISCARD) and the default `RESET_PC` belong in the shared `rv32i_types` package.
- One sub-module, `redirect_counter` (a 32-bit saturating-free incrementer with enable), instantiated twice and only under `FETCH_PERF_CNT_EN`.

## Test plan
- Reset release, memory answering 1 cycle after request with 32'h0000_0013 -> `imem_addr`=32'h6000_0000, then `if_valid`=1, `if_pc`=32'h6000_0000, then next fetch at 32'h6000_0004.
- `stall`=1 for 5 cycles in VALID -> `if_valid`, `if_pc`, `if_instr` constant, `imem_read`=0 throughout.
- `br_valid`=1, `br_en`=1, `target`=32'h6000_0103 while a fetch is outstanding -> `flush`=1 that cycle, old address held until `imem_resp`, data dropped, next `imem_addr`=32'h6000_0100.
- `br_valid`=1, `br_en`=0, `jump`=0 in VALID with `stall`=0 -> no flush, sequential `pc`+4.
- Two redirects during DISCARD (targets 32'h100, then 32'h200) -> single dropped response, then fetch at 32'h200; with macro defined `redirect_cnt`=2, `discard_cnt`=1.
- `rst` pulsed mid-DISCARD -> outputs return to reset values immediately and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I core types: fetch FSM states and the default reset PC.
package rv32i_types;
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        VALID   = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h6000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
endpackage

// File: rtl/definitions.sv
// Shared RV32I funct3 encodings used by the branch/jump datapath.
`ifndef DEFINITIONS_SV
`define DEFINITIONS_SV
`define FUNCT3_BEQ  3'b000
`define FUNCT3_BNE  3'b001
`define FUNCT3_BLT  3'b100
`define FUNCT3_BGE  3'b101
`define FUNCT3_BLTU 3'b110
`define FUNCT3_BGEU 3'b111
`define FUNCT3_JALR 3'b000
`endif

// File: rtl/redirect_counter.sv
// 32-bit wrapping event counter with enable, used for fetch perf statistics.
module redirect_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     cnt <= 32'd0;
        else if (en) cnt <= cnt + 32'd1;
    end
endmodule

// File: rtl/fetch_redirect_unit.sv
// PC owner and imem fetch handshake with redirect/discard and a one-entry decode hold buffer.
// Optional perf counters (redirect_cnt, discard_cnt) under FETCH_PERF_CNT_EN.
module fetch_redirect_unit
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_valid,
    input  logic        br_en,
    input  logic        jump,
    input  logic [31:0] target,
    input  logic        stall,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        flush
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] redirect_cnt,
    output logic [31:0] discard_cnt
`endif
);
    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n, pc_pend, pc_pend_n;
    logic         if_valid_n;
    logic [31:0]  if_pc_n, if_instr_n;
    logic         redirect;
    logic [31:0]  tgt;

    assign redirect = br_valid & (br_en | jump);
    assign flush    = redirect;
    assign tgt      = target & ~32'h3;

    // Request stays up in FETCH and DISCARD; the address is the old pc in DISCARD.
    assign imem_read = ~rst & (state != VALID);
    assign imem_addr = pc;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        pc_pend_n  = pc_pend;
        if_valid_n = if_valid;
        if_pc_n    = if_pc;
        if_instr_n = if_instr;
        case (state)
            FETCH: begin
                if (redirect) begin
                    if (imem_resp) begin
                        pc_n = tgt;
                    end else begin
                        pc_pend_n = tgt;
                        state_n   = DISCARD;
                    end
                end else if (imem_resp) begin
                    if_valid_n = 1'b1;
                    if_pc_n    = pc;
                    if_instr_n = imem_rdata;
                    state_n    = VALID;
                end
            end
            VALID: begin
                if (redirect) begin
                    if_valid_n = 1'b0;
                    pc_n       = tgt;
                    state_n    = FETCH;
                end else if (!stall) begin
                    if_valid_n = 1'b0;
                    pc_n       = pc + PC_STEP;
                    state_n    = FETCH;
                end
            end
            DISCARD: begin
                if (imem_resp) begin
                    pc_n    = redirect ? tgt : pc_pend;
                    state_n = FETCH;
                end else if (redirect) begin
                    pc_pend_n = tgt;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            pc_pend  <= 32'd0;
            if_valid <= 1'b0;
            if_pc    <= RESET_PC;
            if_instr <= 32'd0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            pc_pend  <= pc_pend_n;
            if_valid <= if_valid_n;
            if_pc    <= if_pc_n;
            if_instr <= if_instr_n;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // A drop is either a memory response we ignore or a held instruction killed by redirect.
    logic discard_evt;
    assign discard_evt = ((state == FETCH)   & redirect & imem_resp) |
                         ((state == DISCARD) & imem_resp) |
                         ((state == VALID)   & redirect);

    redirect_counter u_redirect_cnt (
        .clk (clk),
        .rst (rst),
        .en  (redirect),
        .cnt (redirect_cnt)
    );

    redirect_counter u_discard_cnt (
        .clk (clk),
        .rst (rst),
        .en  (discard_evt),
        .cnt (discard_cnt)
    );
`endif
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed self-checking bench for fetch_redirect_unit.
module tb_fetch_redirect_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        br_valid, br_en, jump, stall;
    logic [31:0] target;
    logic        imem_read, imem_resp;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid, flush;
    logic [31:0] if_pc, if_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] redirect_cnt, discard_cnt;
`endif
    int npass = 0;
    int ntotal = 0;

    fetch_redirect_unit dut (
        .clk        (clk),
        .rst        (rst),
        .br_valid   (br_valid),
        .br_en      (br_en),
        .jump       (jump),
        .target     (target),
        .stall      (stall),
        .imem_read  (imem_read),
        .imem_addr  (imem_addr),
        .imem_resp  (imem_resp),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .flush      (flush)
`ifdef FETCH_PERF_CNT_EN
        ,
        .redirect_cnt (redirect_cnt),
        .discard_cnt  (discard_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change at negedge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic set_br(input logic v, input logic en, input logic j, input logic [31:0] t);
        br_valid = v; br_en = en; jump = j; target = t;
    endtask

    task automatic test_reset();
        rst = 1'b1; set_br(0, 0, 0, 32'h0); stall = 1'b0; imem_resp = 1'b0; imem_rdata = 32'h0;
        @(negedge clk); #1;
        ntotal++; if (imem_read !== 1'b0) $display("FAIL reset_imem_read got=%b exp=0", imem_read); else npass++;
        ntotal++; if (if_valid !== 1'b0) $display("FAIL reset_if_valid got=%b exp=0", if_valid); else npass++;
        ntotal++; if (if_pc !== 32'h6000_0000) $display("FAIL reset_if_pc got=%h exp=60000000", if_pc); else npass++;
        ntotal++; if (if_instr !== 32'h0) $display("FAIL reset_if_instr got=%h exp=0", if_instr); else npass++;
        step();
        rst = 1'b0; #1;
        ntotal++; if (imem_read !== 1'b1) $display("FAIL release_imem_read got=%b exp=1", imem_read); else npass++;
        ntotal++; if (imem_addr !== 32'h6000_0000) $display("FAIL release_addr got=%h exp=60000000", imem_addr); else npass++;
    endtask

    task automatic test_first_fetch();
        step();                                   // memory waits one cycle
        imem_resp = 1'b1; imem_rdata = 32'h0000_0013;
        step();
        imem_resp = 1'b0; imem_rdata = 32'hDEAD_BEEF; #1;
        ntotal++; if (if_valid !== 1'b1) $display("FAIL first_if_valid got=%b exp=1", if_valid); else npass++;
        ntotal++; if (if_pc !== 32'h6000_0000) $display("FAIL first_if_pc got=%h exp=60000000", if_pc); else npass++;
        ntotal++; if (if_instr !== 32'h0000_0013) $display("FAIL first_if_instr got=%h exp=00000013", if_instr); else npass++;
        ntotal++; if (imem_read !== 1'b0) $display("FAIL first_valid_read got=%b exp=0", imem_read); else npass++;
        step();
        ntotal++; if (imem_addr !== 32'h6000_0004 || imem_read !== 1'b1)
            $display("FAIL next_fetch got=%b/%h exp=1/60000004", imem_read, imem_addr); else npass++;
        ntotal++; if (if_valid !== 1'b0) $display("FAIL next_fetch_if_valid got=%b exp=0", if_valid); else npass++;
    endtask

    task automatic test_stall();
        imem_resp = 1'b1; imem_rdata = 32'h0010_0093; stall = 1'b1;
        step();
        imem_resp = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ntotal++; if (if_valid !== 1'b1 || if_pc !== 32'h6000_0004 || if_instr !== 32'h0010_0093 || imem_read !== 1'b0)
                $display("FAIL stall_hold[%0d] got=%b/%h/%h/%b exp=1/60000004/00100093/0", i, if_valid, if_pc, if_instr, imem_read);
            else npass++;
            step();
        end
        stall = 1'b0;
        step();
        ntotal++; if (imem_addr !== 32'h6000_0008 || imem_read !== 1'b1)
            $display("FAIL stall_release got=%b/%h exp=1/60000008", imem_read, imem_addr); else npass++;
    endtask

    task automatic test_not_taken();
        imem_resp = 1'b1; imem_rdata = 32'h0020_0113;
        step();
        imem_resp = 1'b0; set_br(1, 0, 0, 32'h1234_5678); #1;
        ntotal++; if (flush !== 1'b0) $display("FAIL not_taken_flush got=%b exp=0", flush); else npass++;
        step();
        set_br(0, 0, 0, 32'h0); #1;
        ntotal++; if (imem_addr !== 32'h6000_000C) $display("FAIL not_taken_pc got=%h exp=6000000c", imem_addr); else npass++;
    endtask

    task automatic test_redirect_inflight();
        set_br(1, 1, 0, 32'h6000_0103); #1;
        ntotal++; if (flush !== 1'b1) $display("FAIL inflight_flush got=%b exp=1", flush); else npass++;
        step();
        set_br(0, 0, 0, 32'h0); #1;
        ntotal++; if (imem_read !== 1'b1 || imem_addr !== 32'h6000_000C)
            $display("FAIL discard_hold got=%b/%h exp=1/6000000c", imem_read, imem_addr); else npass++;
        step();
        ntotal++; if (imem_addr !== 32'h6000_000C) $display("FAIL discard_hold2 got=%h exp=6000000c", imem_addr); else npass++;
        imem_resp = 1'b1; imem_rdata = 32'hBAD0_0BAD;
        step();
        imem_resp = 1'b0; #1;
        ntotal++; if (imem_addr !== 32'h6000_0100 || imem_read !== 1'b1)
            $display("FAIL inflight_target got=%b/%h exp=1/60000100", imem_read, imem_addr); else npass++;
        ntotal++; if (if_valid !== 1'b0) $display("FAIL inflight_dropped got=%b exp=0", if_valid); else npass++;
    endtask

    task automatic test_jump_over_stall();
        imem_resp = 1'b1; imem_rdata = 32'h0000_006F;
        step();
        imem_resp = 1'b0; stall = 1'b1; set_br(1, 0, 1, 32'h6000_0200); #1;
        ntotal++; if (flush !== 1'b1) $display("FAIL jump_flush got=%b exp=1", flush); else npass++;
        step();
        set_br(0, 0, 0, 32'h0); stall = 1'b0; #1;
        ntotal++; if (if_valid !== 1'b0 || imem_addr !== 32'h6000_0200)
            $display("FAIL jump_target got=%b/%h exp=0/60000200", if_valid, imem_addr); else npass++;
    endtask

    task automatic test_redirect_with_resp();
        imem_resp = 1'b1; imem_rdata = 32'h1111_1111; set_br(1, 1, 0, 32'hFFFF_FFFC);
        step();
        imem_resp = 1'b0; set_br(0, 0, 0, 32'h0); #1;
        ntotal++; if (imem_addr !== 32'hFFFF_FFFC || if_valid !== 1'b0)
            $display("FAIL resp_redirect got=%b/%h exp=0/fffffffc", if_valid, imem_addr); else npass++;
        imem_resp = 1'b1; imem_rdata = 32'h2222_2222;
        step();
        imem_resp = 1'b0; #1;
        ntotal++; if (if_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_if_pc got=%h exp=fffffffc", if_pc); else npass++;
        step();
        ntotal++; if (imem_addr !== 32'h0) $display("FAIL pc_wrap got=%h exp=0", imem_addr); else npass++;
    endtask

    task automatic test_reset_mid_discard();
        set_br(1, 1, 0, 32'h6000_0400);
        step();
        set_br(0, 0, 0, 32'h0);
        step();
        rst = 1'b1; #1;
        ntotal++; if (imem_read !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h6000_0000 || if_instr !== 32'h0)
            $display("FAIL mid_reset got=%b/%b/%h/%h exp=0/0/60000000/0", imem_read, if_valid, if_pc, if_instr); else npass++;
        step();
        rst = 1'b0; #1;
        ntotal++; if (imem_read !== 1'b1 || imem_addr !== 32'h6000_0000)
            $display("FAIL mid_reset_restart got=%b/%h exp=1/60000000", imem_read, imem_addr); else npass++;
    endtask

    task automatic test_double_discard();
        set_br(1, 1, 0, 32'h100);
        step();
        set_br(1, 0, 1, 32'h200); #1;
        ntotal++; if (imem_addr !== 32'h6000_0000) $display("FAIL dbl_hold got=%h exp=60000000", imem_addr); else npass++;
        step();
        set_br(0, 0, 0, 32'h0); imem_resp = 1'b1; imem_rdata = 32'h3333_3333; #1;
        ntotal++; if (imem_addr !== 32'h6000_0000) $display("FAIL dbl_hold2 got=%h exp=60000000", imem_addr); else npass++;
        step();
        imem_resp = 1'b0; #1;
        ntotal++; if (imem_addr !== 32'h200 || if_valid !== 1'b0)
            $display("FAIL dbl_last_wins got=%b/%h exp=0/00000200", if_valid, imem_addr); else npass++;
`ifdef FETCH_PERF_CNT_EN
        ntotal++; if (redirect_cnt !== 32'd2) $display("FAIL redirect_cnt got=%0d exp=2", redirect_cnt); else npass++;
        ntotal++; if (discard_cnt !== 32'd1) $display("FAIL discard_cnt got=%0d exp=1", discard_cnt); else npass++;
`endif
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_not_taken();
        test_redirect_inflight();
        test_jump_over_stall();
        test_redirect_with_resp();
        test_reset_mid_discard();
        test_double_discard();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
